// File: rtl/tile_scheduler.sv
// tile_scheduler: accepts one matrix-operation command and walks the tile grid
// in row-major order. For each tile it presents the tile coordinates and the
// op code, pulses tp_start for one cycle, then waits for a rising edge on
// tp_done. Progress, elapsed cycles and a per-tile watchdog timeout are
// reported back to the host. All outputs are registered.
module tile_scheduler #(
  parameter int TILE_IDX_W     = 3,
  parameter int OP_W           = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CYC_W          = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OP_W-1:0]         cmd_op,
  input  logic [TILE_IDX_W-1:0]   cmd_rows,
  input  logic [TILE_IDX_W-1:0]   cmd_cols,
  input  logic                    abort,
  output logic                    tp_start,
  output logic [TILE_IDX_W-1:0]   tp_tile_i,
  output logic [TILE_IDX_W-1:0]   tp_tile_j,
  output logic [OP_W-1:0]         tp_op_code,
  input  logic                    tp_done,
  output logic                    busy,
  output logic                    sched_done,
  output logic                    err_timeout,
  output logic [2*TILE_IDX_W:0]   tiles_done,
  output logic [CYC_W-1:0]        cycle_count
);

  // Watchdog only needs to count up to TIMEOUT_CYCLES-1.
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t                  state;
  logic [TILE_IDX_W-1:0]   rows_q;
  logic [TILE_IDX_W-1:0]   cols_q;
  logic [WD_W-1:0]         watchdog;
  logic                    tp_done_q;
  logic                    done_rise;
  logic                    col_last;
  logic                    last_tile;

  // Only a rising edge counts as completion, so a level left high by the
  // previous tile cannot complete the next one.
  assign done_rise = tp_done & ~tp_done_q;
  assign col_last  = (tp_tile_j == cols_q);
  assign last_tile = (tp_tile_i == rows_q) && col_last;

  // Track tp_done every cycle, regardless of state, for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_done_q <= 1'b0;
    end else begin
      tp_done_q <= tp_done;
    end
  end

  // Command sequencer: state, registered handshake/status outputs and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      tp_start    <= 1'b0;
      tp_tile_i   <= '0;
      tp_tile_j   <= '0;
      tp_op_code  <= '0;
      sched_done  <= 1'b0;
      err_timeout <= 1'b0;
      tiles_done  <= '0;
      cycle_count <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      watchdog    <= '0;
    end else begin
      tp_start   <= 1'b0;
      sched_done <= 1'b0;

      // Every non-idle cycle is charged to the command; saturate at all-ones.
      if (state != S_IDLE && cycle_count != '1) begin
        cycle_count <= cycle_count + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state       <= S_ISSUE;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            tp_start    <= 1'b1;
            tp_op_code  <= cmd_op;
            rows_q      <= cmd_rows;
            cols_q      <= cmd_cols;
            tp_tile_i   <= '0;
            tp_tile_j   <= '0;
            tiles_done  <= '0;
            cycle_count <= '0;
            err_timeout <= 1'b0;
          end
        end

        S_ISSUE: begin
          if (abort) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state    <= S_WAIT;
            watchdog <= '0;
          end
        end

        S_WAIT: begin
          if (abort) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (done_rise) begin
            // Completion beats a timeout that lands in the same cycle.
            tiles_done <= tiles_done + 1'b1;
            if (last_tile) begin
              state      <= S_FINISH;
              sched_done <= 1'b1;
            end else begin
              state <= S_NEXT;
            end
          end else if (watchdog == WD_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_FINISH;
            sched_done  <= 1'b1;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end

        S_NEXT: begin
          if (abort) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            if (col_last) begin
              tp_tile_j <= '0;
              tp_tile_i <= tp_tile_i + 1'b1;
            end else begin
              tp_tile_j <= tp_tile_j + 1'b1;
            end
            state    <= S_ISSUE;
            tp_start <= 1'b1;
          end
        end

        S_FINISH: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Testbench for tile_scheduler: a behavioural tile_processor responder, a
// table of directed commands, hand-written abort / busy / reset sequences and
// randomized commands checked against a cycle-cost model of the command.
module tb_tile_scheduler;

  localparam int W   = 3;
  localparam int OPW = 3;
  localparam int TO  = 16;
  localparam int CW  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [OPW-1:0]  cmd_op = '0;
  logic [W-1:0]    cmd_rows = '0;
  logic [W-1:0]    cmd_cols = '0;
  logic            abort = 1'b0;
  logic            tp_start;
  logic [W-1:0]    tp_tile_i;
  logic [W-1:0]    tp_tile_j;
  logic [OPW-1:0]  tp_op_code;
  logic            tp_done = 1'b0;
  logic            busy;
  logic            sched_done;
  logic            err_timeout;
  logic [2*W:0]    tiles_done;
  logic [CW-1:0]   cycle_count;

  tile_scheduler #(
    .TILE_IDX_W     (W),
    .OP_W           (OPW),
    .TIMEOUT_CYCLES (TO),
    .CYC_W          (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rows    (cmd_rows),
    .cmd_cols    (cmd_cols),
    .abort       (abort),
    .tp_start    (tp_start),
    .tp_tile_i   (tp_tile_i),
    .tp_tile_j   (tp_tile_j),
    .tp_op_code  (tp_op_code),
    .tp_done     (tp_done),
    .busy        (busy),
    .sched_done  (sched_done),
    .err_timeout (err_timeout),
    .tiles_done  (tiles_done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder state. Modes: 0 pulse after lat, 1 level from lat until next
  // start, 2 stale level (high, low at +2, high again at +4), 3 never done.
  int since     = 1000;
  int resp_mode = 0;
  int tile_idx  = 0;
  int cur_lat   = 1;
  int lat_arr[64];

  typedef struct {
    int rows;
    int cols;
    int op;
    int mode;
    int lat;
    int exp_td;
    int exp_cyc;
    int exp_to;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called right after each negedge sample: follow tp_start, drive tp_done.
  task automatic resp_drive();
    if (tp_start) begin
      since = 0;
      if (tile_idx < 64) cur_lat = lat_arr[tile_idx];
      tile_idx++;
    end else begin
      since++;
    end
    case (resp_mode)
      0:       tp_done = (since == cur_lat);
      1:       tp_done = (since >= cur_lat);
      2:       tp_done = !(since == 2 || since == 3);
      default: tp_done = 1'b0;
    endcase
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"},   cmd_ready,   1);
    chk({tag, "_tp_start"},    tp_start,    0);
    chk({tag, "_tile_i"},      tp_tile_i,   0);
    chk({tag, "_tile_j"},      tp_tile_j,   0);
    chk({tag, "_op_code"},     tp_op_code,  0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_sched_done"},  sched_done,  0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_tiles_done"},  tiles_done,  0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // Issue one command and follow it to IDLE. Expected start times, finish
  // time and final counters come from a per-tile cost model: a completed
  // tile costs ISSUE + lat WAIT cycles (+1 NEXT unless last); a timed-out
  // tile costs ISSUE + TO WAIT cycles and ends the command; FINISH adds 1.
  task automatic run_cmd(input int rows, input int cols, input int op, input int mode,
                         input string tag, output int td_act, output int cyc_act,
                         output int to_act);
    int exp_start[$];
    int n;
    int t;
    int exp_td;
    int exp_to;
    int n_start;
    int n_done;
    int end_cyc;
    int lat;
    n = (rows + 1) * (cols + 1);
    t = 0;
    exp_td = 0;
    exp_to = 0;
    for (int k = 0; k < n; k++) begin
      lat = (mode == 2) ? 4 : (mode == 3) ? (1 << 20) : lat_arr[k];
      exp_start.push_back(t);
      if (lat <= TO) begin
        t += lat + 1;
        exp_td++;
        if (k != n - 1) t += 1;
      end else begin
        t += 1 + TO;
        exp_to = 1;
        break;
      end
    end

    n_start = 0;
    n_done = 0;
    end_cyc = -1;
    @(negedge clk);
    chk({tag, "_ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = OPW'(op);
    cmd_rows  = W'(rows);
    cmd_cols  = W'(cols);
    since     = 1000;
    tile_idx  = 0;
    resp_mode = mode;
    resp_drive();
    for (int cyc = 0; cyc < t + 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) cmd_valid = 1'b0;
      if (tp_start) begin
        if (n_start < exp_start.size()) begin
          chk($sformatf("%s_start%0d_cycle", tag, n_start), cyc, exp_start[n_start]);
          chk($sformatf("%s_start%0d_i", tag, n_start), tp_tile_i, n_start / (cols + 1));
          chk($sformatf("%s_start%0d_j", tag, n_start), tp_tile_j, n_start % (cols + 1));
          chk($sformatf("%s_start%0d_op", tag, n_start), tp_op_code, op);
        end
        n_start++;
      end
      if (sched_done) begin
        n_done++;
        chk({tag, "_sched_done_cycle"}, cyc, t);
      end
      if (cyc > 0 && !busy) begin
        end_cyc = cyc;
        break;
      end
      resp_drive();
    end
    chk({tag, "_end_cycle"}, end_cyc, t + 1);
    chk({tag, "_num_starts"}, n_start, exp_start.size());
    chk({tag, "_num_sched_done"}, n_done, 1);
    chk({tag, "_model_tiles_done"}, tiles_done, exp_td);
    chk({tag, "_model_cycle_count"}, cycle_count, t + 1);
    chk({tag, "_model_err_timeout"}, err_timeout, exp_to);
    td_act  = int'(tiles_done);
    cyc_act = int'(cycle_count);
    to_act  = int'(err_timeout);
  endtask

  // Abort during WAIT of tile (0,1) in a 2x2 grid.
  task automatic run_abort();
    int starts;
    int dones;
    int s_cyc;
    logic [CW-1:0] cc_hold;
    starts = 0;
    dones = 0;
    s_cyc = -1;
    cc_hold = '0;
    for (int k = 0; k < 64; k++) lat_arr[k] = 3;
    resp_mode = 0;
    since = 1000;
    tile_idx = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd2;
    cmd_rows = 3'd1;
    cmd_cols = 3'd1;
    resp_drive();
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      abort = 1'b0;
      if (cyc == 0) cmd_valid = 1'b0;
      if (tp_start) begin
        starts++;
        if (starts == 2) begin
          s_cyc = cyc;
          chk("abort_second_tile_j", tp_tile_j, 1);
        end
      end
      if (sched_done) dones++;
      if (s_cyc >= 0 && cyc == s_cyc + 2) abort = 1'b1;
      if (s_cyc >= 0 && cyc == s_cyc + 3) begin
        chk("abort_busy_falls", busy, 0);
        chk("abort_ready_back", cmd_ready, 1);
        cc_hold = cycle_count;
      end
      resp_drive();
    end
    chk("abort_second_start_cycle", s_cyc, 5);
    chk("abort_num_starts", starts, 2);
    chk("abort_no_sched_done", dones, 0);
    chk("abort_tiles_done", tiles_done, 1);
    chk("abort_cycle_count_holds", cycle_count, cc_hold);
  endtask

  // Command held high through a run, accepted on return to IDLE; then an
  // asynchronous reset lands in the middle of WAIT.
  task automatic run_busy_reset();
    for (int k = 0; k < 64; k++) lat_arr[k] = 2;
    lat_arr[1] = 100;
    resp_mode = 0;
    since = 1000;
    tile_idx = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    cmd_rows = 3'd0;
    cmd_cols = 3'd0;
    resp_drive();
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc <= 3) chk($sformatf("busy_ready_low_c%0d", cyc), cmd_ready, 0);
      if (cyc == 3) chk("busy_first_sched_done", sched_done, 1);
      if (cyc == 4) chk("busy_ready_in_idle", cmd_ready, 1);
      if (cyc == 5) begin
        chk("busy_held_cmd_accepted", tp_start, 1);
        cmd_valid = 1'b0;
      end
      if (cyc == 7) chk("busy_in_wait", busy, 1);
      resp_drive();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    tp_done = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int td;
    int cy;
    int tov;
    int rr;
    int cc;
    int md;

    vecs[0] = '{0, 0, 0, 0, 5,  1,   7, 0};
    vecs[1] = '{1, 2, 5, 0, 3,  6,  30, 0};
    vecs[2] = '{1, 1, 2, 3, 0,  0,  18, 1};
    vecs[3] = '{0, 1, 3, 0, 2,  2,   8, 0};
    vecs[4] = '{0, 1, 4, 2, 0,  2,  12, 0};
    vecs[5] = '{1, 1, 7, 1, 1,  4,  12, 0};
    vecs[6] = '{0, 0, 1, 0, 16, 1,  18, 0};
    vecs[7] = '{0, 0, 6, 0, 17, 0,  18, 1};
    vecs[8] = '{7, 7, 6, 0, 1, 64, 192, 0};

    #1 rst_n = 1'b0;
    #2;
    check_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < 64; k++) lat_arr[k] = vecs[v].lat;
      run_cmd(vecs[v].rows, vecs[v].cols, vecs[v].op, vecs[v].mode,
              $sformatf("vec%0d", v), td, cy, tov);
      chk($sformatf("vec%0d_tiles_done", v), td, vecs[v].exp_td);
      chk($sformatf("vec%0d_cycle_count", v), cy, vecs[v].exp_cyc);
      chk($sformatf("vec%0d_err_timeout", v), tov, vecs[v].exp_to);
      $display("vec%0d rows=%0d cols=%0d mode=%0d tiles_done=%0d cycles=%0d timeout=%0d",
               v, vecs[v].rows, vecs[v].cols, vecs[v].mode, td, cy, tov);
    end

    run_abort();
    $display("abort sequence: tiles_done=%0d cycle_count=%0d", tiles_done, cycle_count);
    for (int k = 0; k < 64; k++) lat_arr[k] = 2;
    run_cmd(0, 0, 5, 0, "post_abort", td, cy, tov);
    chk("post_abort_tiles_done", td, 1);
    chk("post_abort_cycle_count", cy, 4);
    $display("post-abort command: tiles_done=%0d cycles=%0d", td, cy);

    run_busy_reset();
    $display("busy/reset sequence done");

    for (int r = 0; r < 25; r++) begin
      rr = $urandom_range(0, 7);
      cc = $urandom_range(0, 7);
      md = $urandom_range(0, 1);
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 24) == 0) lat_arr[k] = $urandom_range(16, 19);
        else lat_arr[k] = $urandom_range(1, 9);
      end
      run_cmd(rr, cc, $urandom_range(0, 7), md, $sformatf("rnd%0d", r), td, cy, tov);
      $display("rnd%0d rows=%0d cols=%0d mode=%0d tiles_done=%0d cycles=%0d timeout=%0d",
               r, rr, cc, md, td, cy, tov);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

endmodule
